// File: rtl/booth_pkg.sv
// Shared digit type, Booth recoding helper and state encoding for the
// sequential radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic booth_digit_t booth_encode(input logic [2:0] triple);
    booth_digit_t digit;
    case (triple)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: the recoded digit times the extended
// multiplicand, sign-extended to the accumulator width and shifted by SHIFT.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHIFT = 0
) (
  input  logic [2:0]         triple,
  input  logic [WIDTH+1:0]   mx,
  output logic [2*WIDTH+1:0] pp
);

  localparam int XW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 2;

  booth_digit_t    digit;
  logic [XW-1:0]   mx_neg;
  logic [AW-1:0]   pos_ext;
  logic [AW-1:0]   neg_ext;
  logic [AW-1:0]   mag;

  // Negation happens at the extended width, so even the most negative
  // operand negates exactly before sign extension.
  always_comb begin
    digit   = booth_encode(triple);
    mx_neg  = ~mx + XW'(1);
    pos_ext = {{(AW-XW){mx[XW-1]}}, mx};
    neg_ext = {{(AW-XW){mx_neg[XW-1]}}, mx_neg};
    case (digit)
      POS1:    mag = pos_ext;
      POS2:    mag = pos_ext << 1;
      NEG1:    mag = neg_ext;
      NEG2:    mag = neg_ext << 1;
      default: mag = '0;
    endcase
    pp = mag << SHIFT;
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier retiring GPC groups per clock, with a
// start/busy/done handshake and signed/unsigned operand modes.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GPC   = 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   M,
  input  logic [WIDTH-1:0]   Q,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int NG   = WIDTH / 2 + 1;
  localparam int NCYC = (NG + GPC - 1) / GPC;
  localparam int XW   = WIDTH + 2;
  localparam int AW   = 2 * WIDTH + 2;
  localparam int QSW  = 2 * GPC * NCYC + 1;
  localparam int CW   = $clog2(NG + GPC + 1);

  logic [1:0]     state;
  logic [CW-1:0]  count;
  logic [AW-1:0]  acc;
  logic [XW-1:0]  mx_r;
  logic [QSW-1:0] q_sh;

  logic [XW-1:0]  mx_init;
  logic [XW-1:0]  qx_init;
  logic [QSW-1:0] q_init;
  logic [AW-1:0]  pp [GPC];
  logic [AW-1:0]  pp_sum;
  logic [AW-1:0]  acc_next;
  logic           last_step;

  // The multiplier register carries Qx[-1]=0 in bit 0 and is sign-padded so
  // that groups past the top of the last cycle recode to a zero digit.
  always_comb begin
    mx_init       = is_signed ? {{2{M[WIDTH-1]}}, M} : {2'b00, M};
    qx_init       = is_signed ? {{2{Q[WIDTH-1]}}, Q} : {2'b00, Q};
    q_init        = {QSW{qx_init[XW-1]}};
    q_init[XW:0]  = {qx_init, 1'b0};
  end

  for (genvar g = 0; g < GPC; g++) begin : g_pp
    booth_pp_gen #(
      .WIDTH (WIDTH),
      .SHIFT (2 * g)
    ) u_pp (
      .triple (q_sh[2*g+2:2*g]),
      .mx     (mx_r),
      .pp     (pp[g])
    );
  end

  always_comb begin
    pp_sum = '0;
    for (int g = 0; g < GPC; g++) begin
      pp_sum = pp_sum + pp[g];
    end
    acc_next  = acc + (pp_sum << {count, 1'b0});
    last_step = (int'(count) + GPC >= NG);
  end

  assign busy = (state == ST_RUN);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
      count <= '0;
      acc   <= '0;
      mx_r  <= '0;
      q_sh  <= '0;
      P     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mx_r  <= mx_init;
            q_sh  <= q_init;
            acc   <= '0;
            count <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc   <= acc_next;
          q_sh  <= {{(2*GPC){q_sh[QSW-1]}}, q_sh[QSW-1:2*GPC]};
          count <= count + CW'(GPC);
          if (last_step) begin
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          P     <= acc[2*WIDTH-1:0];
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed 32x32 cases on GPC=1, and
// randomised scoreboard runs on a GPC=4 instance and an 8-bit instance.
module tb_booth_mul_seq;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        s1_start, s1_sgn, s1_busy, s1_done;
  logic [31:0] s1_m, s1_q;
  logic [63:0] s1_p;
  logic        s4_start, s4_sgn, s4_busy, s4_done;
  logic [31:0] s4_m, s4_q;
  logic [63:0] s4_p;
  logic        s8_start, s8_sgn, s8_busy, s8_done;
  logic [7:0]  s8_m, s8_q;
  logic [15:0] s8_p;

  logic [63:0] sb1 [$];
  logic [63:0] sb4 [$];
  logic [15:0] sb8 [$];
  logic [63:0] last_p1;
  logic [63:0] pre_p1;
  int          lat1;
  int          busy1;

  booth_mul_seq #(.WIDTH(32), .GPC(1)) dut1 (
    .clk(clk), .clr(clr), .start(s1_start), .is_signed(s1_sgn), .M(s1_m), .Q(s1_q),
    .busy(s1_busy), .done(s1_done), .P(s1_p));
  booth_mul_seq #(.WIDTH(32), .GPC(4)) dut4 (
    .clk(clk), .clr(clr), .start(s4_start), .is_signed(s4_sgn), .M(s4_m), .Q(s4_q),
    .busy(s4_busy), .done(s4_done), .P(s4_p));
  booth_mul_seq #(.WIDTH(8), .GPC(1)) dut8 (
    .clk(clk), .clr(clr), .start(s8_start), .is_signed(s8_sgn), .M(s8_m), .Q(s8_q),
    .busy(s8_busy), .done(s8_done), .P(s8_p));

  function automatic logic [63:0] ref32(input logic [31:0] m, input logic [31:0] q, input logic s);
    logic [63:0] a, b;
    a = s ? {{32{m[31]}}, m} : {32'b0, m};
    b = s ? {{32{q[31]}}, q} : {32'b0, q};
    return a * b;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] m, input logic [7:0] q, input logic s);
    logic [15:0] a, b;
    a = s ? {{8{m[7]}}, m} : {8'b0, m};
    b = s ? {{8{q[7]}}, q} : {8'b0, q};
    return a * b;
  endfunction

  // Called at a falling edge; start is sampled on the next rising edge and
  // the operands are scrambled afterwards to prove they were captured.
  task automatic start1(input logic [31:0] m, input logic [31:0] q, input logic s,
                        input logic [63:0] exp);
    s1_m = m; s1_q = q; s1_sgn = s; s1_start = 1'b1;
    sb1.push_back(exp);
    @(negedge clk);
    s1_start = 1'b0; s1_m = ~m; s1_q = ~q; s1_sgn = ~s;
  endtask

  task automatic wait_done1(input bit inject);
    int n;
    n = 0; lat1 = -1; pre_p1 = '0;
    busy1 = (s1_busy === 1'b1) ? 1 : 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (inject && n == 3) begin
        s1_start = 1'b1; s1_m = 32'd5; s1_q = 32'd5;
      end else if (inject && n == 4) begin
        s1_start = 1'b0;
      end
      if (n == 17) pre_p1 = s1_p;
      if (s1_busy === 1'b1) busy1++;
      if (s1_done === 1'b1) begin
        lat1 = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    s1_start = 1'b0; s1_sgn = 1'b0; s1_m = '0; s1_q = '0;
    s4_start = 1'b0; s4_sgn = 1'b0; s4_m = '0; s4_q = '0;
    s8_start = 1'b0; s8_sgn = 1'b0; s8_m = '0; s8_q = '0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (s1_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy1 got %b want 0", s1_busy); end
    if (s1_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done1 got %b want 0", s1_done); end
    if (s1_p !== 64'd0) begin errors++; $display("[TB] FAIL reset_p1 got %h want 0", s1_p); end
    checks += 3;
    if (s4_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy4 got %b want 0", s4_busy); end
    if (s4_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done4 got %b want 0", s4_done); end
    if (s4_p !== 64'd0) begin errors++; $display("[TB] FAIL reset_p4 got %h want 0", s4_p); end
    checks += 3;
    if (s8_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy8 got %b want 0", s8_busy); end
    if (s8_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done8 got %b want 0", s8_done); end
    if (s8_p !== 16'd0) begin errors++; $display("[TB] FAIL reset_p8 got %h want 0", s8_p); end
    clr = 1'b0;
    last_p1 = 64'd0;
    @(negedge clk);
  endtask

  task automatic test_basic_latency();
    logic [63:0] exp;
    start1(32'hFFFF_FFF9, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done1(1'b0);
    checks++;
    if (lat1 != 18) begin errors++; $display("[TB] FAIL basic_latency got %0d want 18", lat1); end
    checks++;
    if (busy1 != 17) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d want 17", busy1); end
    checks++;
    if (pre_p1 !== last_p1) begin errors++; $display("[TB] FAIL basic_p_held got %h want %h", pre_p1, last_p1); end
    exp = sb1.pop_front();
    checks++;
    if (s1_p !== exp) begin errors++; $display("[TB] FAIL basic_product got %h want %h", s1_p, exp); end
    last_p1 = exp;
    @(negedge clk);
    checks++;
    if (s1_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got %b want 0", s1_done); end
  endtask

  task automatic test_corners();
    logic [31:0] tm [4];
    logic [31:0] tq [4];
    logic        ts [4];
    logic [63:0] te [4];
    logic [63:0] exp;
    tm = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    tq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    ts = '{1'b0, 1'b1, 1'b1, 1'b1};
    te = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001,
           64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000};
    for (int i = 0; i < 4; i++) begin
      start1(tm[i], tq[i], ts[i], te[i]);
      wait_done1(1'b0);
      checks++;
      if (lat1 != 18) begin errors++; $display("[TB] FAIL corner%0d_latency got %0d want 18", i, lat1); end
      exp = sb1.pop_front();
      checks++;
      if (s1_p !== exp) begin errors++; $display("[TB] FAIL corner%0d_product got %h want %h", i, s1_p, exp); end
      last_p1 = exp;
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    start1(32'd6, 32'd7, 1'b0, 64'd42);
    wait_done1(1'b1);
    checks++;
    if (lat1 != 18) begin errors++; $display("[TB] FAIL ignored_start_latency got %0d want 18", lat1); end
    exp = sb1.pop_front();
    checks++;
    if (s1_p !== exp) begin errors++; $display("[TB] FAIL ignored_start_product got %h want %h", s1_p, exp); end
    last_p1 = exp;
    start1(32'd5, 32'd5, 1'b0, 64'd25);
    wait_done1(1'b0);
    checks++;
    if (lat1 != 18) begin errors++; $display("[TB] FAIL b2b_latency got %0d want 18", lat1); end
    checks++;
    if (pre_p1 !== last_p1) begin errors++; $display("[TB] FAIL b2b_p_held got %h want %h", pre_p1, last_p1); end
    exp = sb1.pop_front();
    checks++;
    if (s1_p !== exp) begin errors++; $display("[TB] FAIL b2b_product got %h want %h", s1_p, exp); end
    last_p1 = exp;
    @(negedge clk);
  endtask

  task automatic test_clr_abort();
    int extra_done;
    logic [63:0] exp;
    s1_m = 32'd9; s1_q = 32'd9; s1_sgn = 1'b0; s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    repeat (5) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    checks += 3;
    if (s1_busy !== 1'b0) begin errors++; $display("[TB] FAIL clr_busy got %b want 0", s1_busy); end
    if (s1_done !== 1'b0) begin errors++; $display("[TB] FAIL clr_done got %b want 0", s1_done); end
    if (s1_p !== 64'd0) begin errors++; $display("[TB] FAIL clr_p got %h want 0", s1_p); end
    #1 clr = 1'b0;
    last_p1 = 64'd0;
    extra_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (s1_done === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done != 0) begin errors++; $display("[TB] FAIL clr_no_done got %0d want 0", extra_done); end
    start1(32'd12345, 32'd678, 1'b0, 64'd8369910);
    wait_done1(1'b0);
    checks++;
    if (lat1 != 18) begin errors++; $display("[TB] FAIL after_clr_latency got %0d want 18", lat1); end
    checks++;
    if (pre_p1 !== last_p1) begin errors++; $display("[TB] FAIL after_clr_p_held got %h want %h", pre_p1, last_p1); end
    exp = sb1.pop_front();
    checks++;
    if (s1_p !== exp) begin errors++; $display("[TB] FAIL after_clr_product got %h want %h", s1_p, exp); end
    @(negedge clk);
  endtask

  task automatic test_random_gpc4();
    logic [31:0] m, q;
    logic        s;
    logic [63:0] exp;
    int          n;
    for (int i = 0; i < 1000; i++) begin
      m = $urandom; q = $urandom; s = i[0];
      case (i)
        0: begin m = 32'h8000_0000; q = 32'h8000_0000; end
        1: begin m = 32'hFFFF_FFFF; q = 32'hFFFF_FFFF; end
        2: begin m = 32'h0000_0000; q = 32'h7FFF_FFFF; end
        3: begin m = 32'h7FFF_FFFF; q = 32'h8000_0000; end
        default: ;
      endcase
      s4_m = m; s4_q = q; s4_sgn = s; s4_start = 1'b1;
      sb4.push_back(ref32(m, q, s));
      @(negedge clk);
      s4_start = 1'b0; s4_m = $urandom; s4_q = $urandom; s4_sgn = ~s;
      n = 0;
      while (s4_done !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n != 6) begin errors++; $display("[TB] FAIL gpc4_latency iter %0d got %0d want 6", i, n); end
      exp = sb4.pop_front();
      checks++;
      if (s4_p !== exp) begin
        errors++;
        $display("[TB] FAIL gpc4_product iter %0d m=%h q=%h s=%b got %h want %h", i, m, q, s, s4_p, exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random_w8();
    logic [7:0]  m, q;
    logic        s;
    logic [15:0] exp;
    int          n;
    for (int i = 0; i < 1000; i++) begin
      m = 8'($urandom); q = 8'($urandom); s = i[0];
      case (i)
        0: begin m = 8'h80; q = 8'h80; end
        1: begin m = 8'hFF; q = 8'hFF; end
        2: begin m = 8'h80; q = 8'h7F; end
        3: begin m = 8'h7F; q = 8'hFF; end
        default: ;
      endcase
      s8_m = m; s8_q = q; s8_sgn = s; s8_start = 1'b1;
      sb8.push_back(ref8(m, q, s));
      @(negedge clk);
      s8_start = 1'b0; s8_m = ~m; s8_q = ~q; s8_sgn = ~s;
      n = 0;
      while (s8_done !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n != 6) begin errors++; $display("[TB] FAIL w8_latency iter %0d got %0d want 6", i, n); end
      exp = sb8.pop_front();
      checks++;
      if (s8_p !== exp) begin
        errors++;
        $display("[TB] FAIL w8_product iter %0d m=%h q=%h s=%b got %h want %h", i, m, q, s, s8_p, exp);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_corners();
    test_back_to_back();
    test_clr_abort();
    test_random_gpc4();
    test_random_w8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Iterative radix-4 Booth multiplier; the clocked successor to the combinational 32x32 Booth array in the ALU datapath.
- Parametrised operand width and number of Booth groups retired per cycle (area/latency trade).
- Adds signed/unsigned mode selection and a start/busy/done handshake.
- Sits beside the ALU; the MUL control step launches it and stalls until done, then writes the HI/LO registers from P.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4.
- GPC, 1, Booth groups processed per clock; range 1 to NG.
- Derived NG = WIDTH/2 + 1 (number of groups over the (WIDTH+2)-bit extended multiplier).
- Derived NCYC = ceil(NG/GPC).

Ports:
- clk  in  1  system clock, rising-edge.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  request a multiply; sampled on rising clk.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- M  in  WIDTH  multiplicand; captured with start.
- Q  in  WIDTH  multiplier; captured with start.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse when P becomes valid.
- P  out  2*WIDTH  product; held stable until the next accepted start.

Behaviour:
- Reset (clr high, async): state=IDLE; busy=0, done=0, P=0; accumulator, group counter and operand registers cleared. A clr during RUN aborts the multiply, and no done is produced.
- Operand extension: M and Q are extended to WIDTH+2 bits, with sign bits when is_signed=1 and zeros when is_signed=0. Groups are triples {Qx[2i+1], Qx[2i], Qx[2i-1]}, with Qx[-1]=0, for i=0..NG-1.
- Digit map:
  - 000 and 111 -> 0.
  - 001 and 010 -> +M.
  - 011 -> +2M.
  - 100 -> -2M.
  - 101 and 110 -> -M.
  - -M is formed as ~Mx+1 at WIDTH+2 bits, so negating the most-negative signed M is exact.
- Partial product for group i: the digit times Mx, sign-extended to 2*WIDTH+2 bits and shifted left by 2i. The accumulator is 2*WIDTH+2 bits; P is its low 2*WIDTH bits, and the result is exact in both modes.
- States:
  - IDLE: busy=0. If start=1, capture M, Q and is_signed, clear the accumulator, set count=0, go to RUN.
  - RUN: busy=1. Each cycle, add partial products for groups count..min(count+GPC,NG)-1, then count += GPC. When the last group has been added, go to FIN.
  - FIN: load P from the accumulator, assert done for this one cycle, then go to IDLE. busy=0 in FIN.
- Latency: if start is sampled at edge t, done=1 and P is valid during the cycle after edge t+NCYC+1. For WIDTH=32, GPC=1 that is 18 edges after the start edge.
- start while busy=1 (RUN) is ignored, and operand changes during RUN have no effect.
- start during FIN is ignored, so back-to-back issue is start in the cycle after done. Throughput is one multiply per NCYC+2 cycles.
- is_signed has no effect outside the capture cycle.
- P is not updated before FIN, so a consumer may read the previous result until done.
- Arithmetic wraps modulo 2^(2*WIDTH+2) internally. No overflow flag is needed, because the product always fits.

Decomposition:
- Package booth_pkg:
  - Enum booth_digit_t (ZERO, POS1, POS2, NEG1, NEG2).
  - Function booth_encode(3-bit triple) -> booth_digit_t.
  - Constants for the state encoding (IDLE, RUN, FIN).
- Sub-module booth_pp_gen (params WIDTH, SHIFT):
  - Inputs: triple, Mx.
  - Output: one shifted, sign-extended partial product.
  - booth_mul_seq instantiates GPC copies in a generate loop, indexed by count.
- Top: FSM, counter, operand/accumulator registers, and the adder tree over the GPC partial products.

Test Plan:
- WIDTH=32, GPC=1, signed, M=-7, Q=3 -> P=0xFFFFFFFF_FFFFFFEB. done pulses exactly 18 edges after the start edge, and busy is high for 17 cycles.
- Unsigned, M=Q=0xFFFFFFFF -> P=0xFFFFFFFE_00000001. The same operands signed -> P=0x00000000_00000001.
- Signed, M=Q=0x80000000 -> P=0x40000000_00000000. Signed, M=0x80000000, Q=0x7FFFFFFF -> P=0xC0000000_80000000.
- start re-asserted with M=5, Q=5 mid-RUN of M=6, Q=7 -> ignored; P=42, a single done. Then start in the cycle after done with M=5, Q=5 -> P=25.
- clr pulse mid-RUN -> busy, done and P go to 0 immediately (async), with no done afterwards. The next start yields a correct result.
- GPC=4, WIDTH=32 (NCYC=5) and WIDTH=8, GPC=1: 1000 random signed and unsigned pairs checked against a reference product, and done latency equal to NCYC+1 edges.
